// File: rtl/wash_cycle_timer.sv
// wash_cycle_timer: timed wash-cycle sequencer (WASH -> RINSE -> SPIN -> DRAIN).
// Latches wash_mode on an accepted start. Each phase lasts a mode-dependent
// number of prescaled ticks. Pause or an open door freezes the timing and
// drops the actuators.
// Optional feature macro: WASH_CYCLE_EXTRA_RINSE_EN. When it is defined, a
// latched Heavy mode inserts RINSE2 (code 5) between RINSE and SPIN.
// Ports:
//   clk, rst (async, active-high)
//   start, door_closed, pause, wash_mode[1:0]        - control inputs
//   wash_motor, rinse_valve, spin_motor, drain_valve - actuator enables
//   door_lock, busy, done (1-cycle pulse), phase[2:0] - status
module wash_cycle_timer #(
   parameter int unsigned TICK_DIV      = 1000,
   parameter int unsigned CNT_W         = 16,
   parameter int unsigned WASH_GENTLE_T = 4,
   parameter int unsigned WASH_NORMAL_T = 6,
   parameter int unsigned WASH_HEAVY_T  = 8,
   parameter int unsigned RINSE_T       = 3,
   parameter int unsigned SPIN_T        = 4,
   parameter int unsigned DRAIN_T       = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       door_closed,
   input  logic       pause,
   input  logic [1:0] wash_mode,
   output logic       wash_motor,
   output logic       rinse_valve,
   output logic       spin_motor,
   output logic       drain_valve,
   output logic       door_lock,
   output logic       busy,
   output logic       done,
   output logic [2:0] phase
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WASH   = 3'd1;
   localparam logic [2:0] S_RINSE  = 3'd2;
   localparam logic [2:0] S_SPIN   = 3'd3;
   localparam logic [2:0] S_DRAIN  = 3'd4;
`ifdef WASH_CYCLE_EXTRA_RINSE_EN
   localparam logic [2:0] S_RINSE2 = 3'd5;
`endif

   localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(TICK_DIV - 1);

   logic [2:0]       state;
   logic [2:0]       state_next;
   logic [1:0]       mode;
   logic [CNT_W-1:0] presc;
   logic [CNT_W-1:0] pcnt;
   logic [CNT_W-1:0] dur;
   logic             run;
   logic             tick;
   logic             last;
   logic             accept;

   // Timing qualifiers. A hold (pause or open door) suppresses ticks.
   assign accept = (state == S_IDLE) & start & door_closed;
   assign busy   = (state != S_IDLE);
   assign run    = busy & ~pause & door_closed;
   assign tick   = run & (presc == PRESC_MAX);
   assign last   = tick & (pcnt == dur - CNT_W'(1));

   // Duration of the current phase, in ticks.
   always_comb begin
      dur = CNT_W'(1);
      case (state)
         S_WASH: begin
            case (mode)
               2'b00:   dur = CNT_W'(WASH_GENTLE_T);
               2'b01:   dur = CNT_W'(WASH_NORMAL_T);
               default: dur = CNT_W'(WASH_HEAVY_T);
            endcase
         end
         S_RINSE: dur = CNT_W'(RINSE_T);
`ifdef WASH_CYCLE_EXTRA_RINSE_EN
         S_RINSE2: dur = CNT_W'(RINSE_T);
`endif
         S_SPIN:  dur = CNT_W'(SPIN_T);
         S_DRAIN: dur = CNT_W'(DRAIN_T);
         default: dur = CNT_W'(1);
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (accept) state_next = S_WASH;
         S_WASH:  if (last)   state_next = S_RINSE;
         S_RINSE: begin
            if (last) begin
`ifdef WASH_CYCLE_EXTRA_RINSE_EN
               state_next = mode[1] ? S_RINSE2 : S_SPIN;
`else
               state_next = S_SPIN;
`endif
            end
         end
`ifdef WASH_CYCLE_EXTRA_RINSE_EN
         S_RINSE2: if (last) state_next = S_SPIN;
`endif
         S_SPIN:  if (last) state_next = S_DRAIN;
         S_DRAIN: if (last) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // State register, mode latch, prescaler and phase counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         mode  <= 2'b00;
         presc <= '0;
         pcnt  <= '0;
      end else begin
         state <= state_next;
         if (!busy) begin
            presc <= '0;
            pcnt  <= '0;
            if (accept) mode <= wash_mode;
         end else if (run) begin
            if (last) begin
               presc <= '0;
               pcnt  <= '0;
            end else if (tick) begin
               presc <= '0;
               pcnt  <= pcnt + CNT_W'(1);
            end else begin
               presc <= presc + CNT_W'(1);
            end
         end
      end
   end

   // Moore decode of the state register, gated off while held.
   assign wash_motor  = run & (state == S_WASH);
`ifdef WASH_CYCLE_EXTRA_RINSE_EN
   assign rinse_valve = run & ((state == S_RINSE) | (state == S_RINSE2));
`else
   assign rinse_valve = run & (state == S_RINSE);
`endif
   assign spin_motor  = run & (state == S_SPIN);
   assign drain_valve = run & (state == S_DRAIN);
   assign door_lock   = busy;
   assign done        = (state == S_DRAIN) & last;
   assign phase       = state;

endmodule
